// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer_a_lite peripheral.
//   - default word addresses of the four registers
//   - MC (mode control) and ID (input divider) encodings
//   - bit positions inside TACTL / TACCTL0
//   - helpers: byte/word write merge, prescaler terminal count
package timer_pkg;

  localparam logic [15:0] TACTL_ADDR_DEF   = 16'h0160;
  localparam logic [15:0] TACCTL0_ADDR_DEF = 16'h0162;
  localparam logic [15:0] TAR_ADDR_DEF     = 16'h0170;
  localparam logic [15:0] TACCR0_ADDR_DEF  = 16'h0172;

  typedef enum logic [1:0] {
    MC_STOP = 2'b00,
    MC_UP   = 2'b01,
    MC_CONT = 2'b10,
    MC_UPDN = 2'b11
  } mc_e;

  typedef enum logic [1:0] {
    ID_DIV1 = 2'b00,
    ID_DIV2 = 2'b01,
    ID_DIV4 = 2'b10,
    ID_DIV8 = 2'b11
  } id_e;

  // TACTL bit positions
  localparam int TAIFG_BIT = 0;
  localparam int TAIE_BIT  = 1;
  localparam int TACLR_BIT = 2;
  localparam int MC_LSB    = 4;
  localparam int ID_LSB    = 6;
  // TACCTL0 bit positions
  localparam int CCIFG_BIT = 0;
  localparam int CCIE_BIT  = 4;

  // Byte writes always take their data from the low lane of the write bus;
  // addr_lsb selects which half of the register is replaced.
  function automatic logic [15:0] merge_write(input logic [15:0] old_val,
                                              input logic [15:0] wdata,
                                              input logic        bw,
                                              input logic        addr_lsb);
    if (!bw)          return wdata;
    else if (addr_lsb) return {wdata[7:0], old_val[7:0]};
    else               return {old_val[15:8], wdata[7:0]};
  endfunction

  // Last prescaler count before a tick (divisor - 1).
  function automatic logic [2:0] div_last(input id_e id);
    case (id)
      ID_DIV1: return 3'd0;
      ID_DIV2: return 3'd1;
      ID_DIV4: return 3'd3;
      ID_DIV8: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk by 1/2/4/8 to produce the counter tick.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   ID        - divider select (id_e)
//   enable    - counting allowed (timer not stopped); count held at 0 otherwise
//   restart   - force count back to 0 this cycle (ID change or TACLR)
//   tick      - one-cycle pulse; the counter advances on the following edge
module timer_prescaler
  import timer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  id_e  ID,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  logic [2:0] count;
  logic       at_last;

  assign at_last = (count == div_last(ID));
  // A restart in the same cycle suppresses the tick so a new divisor
  // always gets a full period.
  assign tick    = enable & ~restart & at_last;

  always_ff @(posedge clk) begin
    if (rst || !enable || restart) count <= 3'd0;
    else if (at_last)              count <= 3'd0;
    else                           count <= count + 3'd1;
  end

endmodule

// File: rtl/timer_a_lite.sv
// timer_a_lite: memory-mapped 16-bit timer with stop/up/continuous/up-down
// modes, input divider and two interrupt requests.
// Bus handshake: there is no valid/ready pair. A write happens on the rising
// clk edge when MW & TA_hit; BW selects a byte write (lane by MAB_in[0]).
// Read data is combinational every cycle, zero when the address misses.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   MAB_in        - address bus (bit 0 selects byte lane)
//   MDB_in        - write data bus
//   MW, BW        - write strobe, byte access
//   irq_ccr0_ack  - CCR0 interrupt accepted, clears CCIFG
//   TA_rdata      - read data of addressed register
//   TA_hit        - address matches one of the four registers
//   irq_ccr0      - CCIE & CCIFG
//   irq_ta        - TAIE & TAIFG
module timer_a_lite
  import timer_pkg::*;
#(
  parameter logic [15:0] TACTL_ADDR   = TACTL_ADDR_DEF,
  parameter logic [15:0] TACCTL0_ADDR = TACCTL0_ADDR_DEF,
  parameter logic [15:0] TAR_ADDR     = TAR_ADDR_DEF,
  parameter logic [15:0] TACCR0_ADDR  = TACCR0_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MAB_in,
  input  logic [15:0] MDB_in,
  input  logic        MW,
  input  logic        BW,
  input  logic        irq_ccr0_ack,
  output logic [15:0] TA_rdata,
  output logic        TA_hit,
  output logic        irq_ccr0,
  output logic        irq_ta
);

  id_e         id_q;
  mc_e         mc_q;
  logic        taie_q, taifg_q, ccie_q, ccifg_q;
  logic        dir_down_q;
  logic [15:0] tar_q, taccr0_q;

  logic [15:0] addr_w, wdata;
  logic        hit_ctl, hit_cctl, hit_tar, hit_ccr;
  logic        wr_ctl, wr_cctl, wr_tar, wr_ccr;
  logic        clr, restart, tick, upd;
  logic [15:0] tar_tick;
  logic        dir_tick, set_taifg, set_ccifg;

  // Address decode and read mux
  assign addr_w   = {MAB_in[15:1], 1'b0};
  assign hit_ctl  = (addr_w == TACTL_ADDR);
  assign hit_cctl = (addr_w == TACCTL0_ADDR);
  assign hit_tar  = (addr_w == TAR_ADDR);
  assign hit_ccr  = (addr_w == TACCR0_ADDR);
  assign TA_hit   = hit_ctl | hit_cctl | hit_tar | hit_ccr;

  always_comb begin
    TA_rdata = 16'h0000;
    if (hit_ctl)  TA_rdata = {8'h00, id_q, mc_q, 2'b00, taie_q, taifg_q};
    if (hit_cctl) TA_rdata = {11'h000, ccie_q, 3'b000, ccifg_q};
    if (hit_tar)  TA_rdata = tar_q;
    if (hit_ccr)  TA_rdata = taccr0_q;
  end

  // The current read value doubles as the merge base for byte writes.
  assign wdata   = merge_write(TA_rdata, MDB_in, BW, MAB_in[0]);
  assign wr_ctl  = MW & hit_ctl;
  assign wr_cctl = MW & hit_cctl;
  assign wr_tar  = MW & hit_tar;
  assign wr_ccr  = MW & hit_ccr;

  assign clr     = wr_ctl & wdata[TACLR_BIT];
  assign restart = clr | (wr_ctl & (wdata[ID_LSB+1:ID_LSB] != id_q));

  timer_prescaler u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .ID      (id_q),
    .enable  (mc_q != MC_STOP),
    .restart (restart),
    .tick    (tick)
  );

  // Software TAR write or TACLR replaces the whole tick effect, flags included.
  assign upd = tick & ~wr_tar & ~clr;

  // Next counter value / direction / flag sets for one tick.
  always_comb begin
    tar_tick  = tar_q;
    dir_tick  = dir_down_q;
    set_taifg = 1'b0;
    set_ccifg = 1'b0;
    case (mc_q)
      MC_STOP: ;
      MC_UP: begin
        if (taccr0_q == 16'h0000) tar_tick = 16'h0000;
        else if (tar_q >= taccr0_q) begin
          tar_tick  = 16'h0000;
          set_taifg = 1'b1;
        end else begin
          tar_tick  = tar_q + 16'd1;
          set_ccifg = (tar_q + 16'd1 == taccr0_q);
        end
      end
      MC_CONT: begin
        tar_tick  = tar_q + 16'd1;
        set_taifg = (tar_q == 16'hFFFF);
      end
      MC_UPDN: begin
        if (taccr0_q == 16'h0000) begin
          tar_tick = 16'h0000;
          dir_tick = 1'b0;
        end else if (!dir_down_q) begin
          if (tar_q >= taccr0_q) begin
            // Above the compare value (e.g. after a software write): head down.
            tar_tick = tar_q - 16'd1;
            dir_tick = 1'b1;
          end else begin
            tar_tick = tar_q + 16'd1;
            if (tar_q + 16'd1 == taccr0_q) begin
              set_ccifg = 1'b1;
              dir_tick  = 1'b1;
            end
          end
        end else begin
          if (tar_q == 16'h0000) begin
            tar_tick = 16'd1;
            dir_tick = 1'b0;
          end else begin
            tar_tick = tar_q - 16'd1;
            if (tar_q == 16'd1) begin
              set_taifg = 1'b1;
              dir_tick  = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q       <= ID_DIV1;
      mc_q       <= MC_STOP;
      taie_q     <= 1'b0;
      taifg_q    <= 1'b0;
      ccie_q     <= 1'b0;
      ccifg_q    <= 1'b0;
      dir_down_q <= 1'b0;
      tar_q      <= 16'h0000;
      taccr0_q   <= 16'h0000;
    end else begin
      if (wr_ctl) begin
        id_q   <= id_e'(wdata[ID_LSB+1:ID_LSB]);
        mc_q   <= mc_e'(wdata[MC_LSB+1:MC_LSB]);
        taie_q <= wdata[TAIE_BIT];
      end
      if (wr_cctl) ccie_q <= wdata[CCIE_BIT];
      if (wr_ccr)  taccr0_q <= wdata;

      // Hardware set wins over software clear and ack; software may set.
      taifg_q <= (upd & set_taifg) | (wr_ctl ? wdata[TAIFG_BIT] : taifg_q);
      ccifg_q <= (upd & set_ccifg) |
                 (wr_cctl ? wdata[CCIFG_BIT] : (irq_ccr0_ack ? 1'b0 : ccifg_q));

      if (wr_tar)   tar_q <= wdata;
      else if (clr) tar_q <= 16'h0000;
      else if (upd) tar_q <= tar_tick;

      if (clr)      dir_down_q <= 1'b0;
      else if (upd) dir_down_q <= dir_tick;
    end
  end

  assign irq_ccr0 = ccie_q & ccifg_q;
  assign irq_ta   = taie_q & taifg_q;

endmodule

// File: tb/tb_timer_a_lite.sv
// Testbench for timer_a_lite: directed register writes and reads; each read
// pushes its expected {hit, irq_ta, irq_ccr0, rdata} into a queue and a
// negedge monitor pops and compares.
module tb_timer_a_lite;
  import timer_pkg::*;

  localparam logic [15:0] A_CTL  = 16'h0160;
  localparam logic [15:0] A_CCTL = 16'h0162;
  localparam logic [15:0] A_TAR  = 16'h0170;
  localparam logic [15:0] A_CCR  = 16'h0172;

  logic        clk, rst;
  logic [15:0] MAB_in, MDB_in;
  logic        MW, BW, irq_ccr0_ack;
  logic [15:0] TA_rdata;
  logic        TA_hit, irq_ccr0, irq_ta;

  logic        rd_req;
  logic [18:0] exp_q[$];
  string       tag_q[$];
  logic [18:0] mon_act, mon_exp;
  string       mon_tag;
  int          tests, fails;

  timer_a_lite dut (
    .clk          (clk),
    .rst          (rst),
    .MAB_in       (MAB_in),
    .MDB_in       (MDB_in),
    .MW           (MW),
    .BW           (BW),
    .irq_ccr0_ack (irq_ccr0_ack),
    .TA_rdata     (TA_rdata),
    .TA_hit       (TA_hit),
    .irq_ccr0     (irq_ccr0),
    .irq_ta       (irq_ta)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, %0d reads still queued", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data, input logic bw = 1'b0);
    rd_req = 1'b0; MAB_in = addr; MDB_in = data; BW = bw; MW = 1'b1;
    step();
    MW = 1'b0; BW = 1'b0;
  endtask

  task automatic rd_full(input logic [15:0] addr, input logic [15:0] data,
                         input logic ta, input logic ccr, input logic hit, input string tag);
    MW = 1'b0; MAB_in = addr; rd_req = 1'b1;
    exp_q.push_back({hit, ta, ccr, data});
    tag_q.push_back(tag);
    step();
    rd_req = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] data, input string tag);
    rd_full(addr, data, 1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic idle();
    rd_req = 1'b0; MW = 1'b0; MAB_in = 16'h0000;
    step();
  endtask

  task automatic ack_pulse();
    rd_req = 1'b0; MW = 1'b0; irq_ccr0_ack = 1'b1;
    step();
    irq_ccr0_ack = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rd_req) begin
      mon_act = {TA_hit, irq_ta, irq_ccr0, TA_rdata};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read: got %h with empty expected queue", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        if (mon_act !== mon_exp)begin
          fails++;
          $display("FAIL %s: got hit=%b irq_ta=%b irq_ccr0=%b rdata=%h, want hit=%b irq_ta=%b irq_ccr0=%b rdata=%h",
                   mon_tag, mon_act[18], mon_act[17], mon_act[16], mon_act[15:0],
                   mon_exp[18], mon_exp[17], mon_exp[16], mon_exp[15:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; MAB_in = 16'h0000; MDB_in = 16'h0000;
    MW = 1'b0; BW = 1'b0; irq_ccr0_ack = 1'b0; rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    rd(A_CTL,  16'h0000, "rst_tactl");
    rd(A_CCTL, 16'h0000, "rst_tacctl0");
    rd(A_TAR,  16'h0000, "rst_tar");
    rd(A_CCR,  16'h0000, "rst_taccr0");
    rd_full(16'h0164, 16'h0000, 1'b0, 1'b0, 1'b0, "miss_0164");

    // Continuous wrap, then TAIE enables irq_ta
    wr(A_TAR, 16'hFFFE);
    wr(A_CTL, 16'h0020);
    rd(A_TAR, 16'hFFFE, "cont_tar0");
    rd(A_TAR, 16'hFFFF, "cont_tar1");
    rd(A_TAR, 16'h0000, "cont_wrap");
    rd(A_CTL, 16'h0021, "cont_taifg_noie");
    wr(A_CTL, 16'h0023);
    rd_full(A_CTL, 16'h0023, 1'b1, 1'b0, 1'b1, "cont_irq_ta");
    wr(A_CTL, 16'h0004);
    rd(A_CTL, 16'h0000, "stop_clear_flags");

    // Up mode, divide by 4, TACCR0 = 3
    wr(A_CCR, 16'h0003);
    wr(A_CTL, 16'h0090);
    for (int j = 0; j < 20; j++) begin
      if (j == 11)      rd(A_CCTL, 16'h0000, "up_ccifg_before");
      else if (j == 12) rd(A_CCTL, 16'h0001, "up_ccifg_at3");
      else if (j == 15) rd(A_CTL,  16'h0090, "up_taifg_before");
      else if (j == 16) rd(A_CTL,  16'h0091, "up_taifg_wrap");
      else              rd(A_TAR,  16'((j / 4) % 4), $sformatf("up_tar_j%0d", j));
    end
    wr(A_CTL, 16'h0004);

    // CCIE / irq_ccr0 / ack
    wr(A_CCTL, 16'h0011);
    rd_full(A_CCTL, 16'h0011, 1'b0, 1'b1, 1'b1, "ccr0_irq_on");
    ack_pulse();
    rd(A_CCTL, 16'h0010, "ccr0_ack_clears");
    wr(A_CCTL, 16'h0000);

    // Up/down, TACCR0 = 2: 0,1,2,1,0,1,2,1
    wr(A_CCR, 16'h0002);
    wr(A_CTL, 16'h0030);
    for (int j = 0; j < 8; j++) begin
      logic [15:0] pat;
      pat = (j % 4 == 3) ? 16'd1 : 16'(j % 4);
      rd(A_TAR, pat, $sformatf("updn_tar_j%0d", j));
    end
    rd(A_CCTL, 16'h0001, "updn_ccifg");
    rd(A_CTL,  16'h0031, "updn_taifg");
    wr(A_CTL, 16'h0004);
    wr(A_CCTL, 16'h0000);

    // Collisions: hardware CCIFG set vs ack, TAR write vs tick
    wr(A_CTL, 16'h0030);
    idle();            // TAR 0 -> 1 at next edge
    ack_pulse();       // edge where TAR becomes 2 and CCIFG sets
    rd(A_CCTL, 16'h0001, "coll_set_beats_ack");
    wr(A_TAR, 16'h0100);
    rd(A_TAR, 16'h0100, "coll_tar_write_wins");
    wr(A_CTL, 16'h0004);
    wr(A_CCTL, 16'h0000);

    // Byte writes, timer stopped
    wr(A_TAR, 16'h1234);
    wr(16'h0171, 16'h00AB, 1'b1);
    rd(A_TAR, 16'hAB34, "byte_high");
    wr(16'h0170, 16'h00CD, 1'b1);
    rd(A_TAR, 16'hABCD, "byte_low");

    // TACLR while running
    wr(A_TAR, 16'h0055);
    wr(A_CTL, 16'h0020);
    idle();
    idle();
    wr(A_CTL, 16'h0024);
    rd(A_TAR, 16'h0000, "taclr_tar");
    rd(A_CTL, 16'h0020, "taclr_reads0");

    // Reset mid-count
    wr(A_CCTL, 16'h0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd(A_CTL,  16'h0000, "rst2_tactl");
    rd(A_CCTL, 16'h0000, "rst2_tacctl0");
    rd(A_TAR,  16'h0000, "rst2_tar");
    rd(A_CCR,  16'h0000, "rst2_taccr0");
    rd_full(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "miss_0000");

    // Drain and final report
    idle();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected reads never observed, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
